// File: rtl/gbus_console_tx.sv
// Console transmitter on the generic bus: TXDATA/STATUS/CLKDIV registers,
// a character FIFO, and an 8N1 UART serializer with a programmable bit period.
module gbus_console_tx #(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] CLKDIV_RESET = 16'd434
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        tx,
    output logic        tx_active
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    // Register indices decoded from addr[3:2].
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;

    logic            pending_q, pending_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [15:0]     clkdiv_q, clkdiv_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    tx_state_e       state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     period_q, period_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem [FIFO_DEPTH];

    logic [AW:0]     count;
    logic            fifo_empty, fifo_full;
    logic            req, is_wr, stall, done, push, pop;
    logic [1:0]      reg_idx;
    logic [31:0]     status;
    logic [15:0]     eff_div;
    logic [2:0]      nxt_idx;
    logic            unused_bits;

    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[23:16], byte_en[2]};

    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);

    // Bus request decode; stall only a TXDATA write against a full FIFO.
    assign req     = sel & (ren | wen);
    assign is_wr   = wen;
    assign reg_idx = addr[3:2];
    assign stall   = is_wr & (reg_idx == REG_TXDATA) & fifo_full;
    assign done    = pending_q & req & ~stall;
    assign push    = done & is_wr & (reg_idx == REG_TXDATA) & byte_en[3];
    assign eff_div = (clkdiv_q == 16'd0) ? 16'd1 : clkdiv_q;

    assign busy      = ~done;
    assign rdata     = rdata_q;
    assign tx        = tx_q;
    assign tx_active = (state_q != IDLE);

    // Bus-side next state: request tracking, read data capture, CLKDIV, push pointer.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pending_d = req & ~done;
        rdata_d   = rdata_q;
        clkdiv_d  = clkdiv_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;

        status       = '0;
        status[0]    = fifo_empty;
        status[1]    = fifo_full;
        status[2]    = tx_active;
        status[12:8] = 5'(count);

        // Read data is captured in the request cycle so it is valid when busy drops.
        if (req && !is_wr && !pending_q) begin
            case (reg_idx)
                REG_STATUS: rdata_d = status;
                REG_CLKDIV: rdata_d = {16'd0, clkdiv_q};
                default:    rdata_d = '0;
            endcase
        end

        if (done && is_wr && reg_idx == REG_CLKDIV) begin
            if (byte_en[0]) clkdiv_d[7:0]  = wdata[7:0];
            if (byte_en[1]) clkdiv_d[15:8] = wdata[15:8];
        end
    end

    // Serializer next state: frame sequencing, bit timing and the registered tx level.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        nxt_idx   = bit_idx_q + 3'd1;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = mem[rd_ptr_q[AW-1:0]];
                    period_d = eff_div;
                    cnt_d    = eff_div - 16'd1;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = period_q - 16'd1;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = period_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = nxt_idx;
                        tx_d      = shift_q[nxt_idx];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    // Chain straight into the next frame when more data is queued.
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_d  = mem[rd_ptr_q[AW-1:0]];
                        period_d = eff_div;
                        cnt_d    = eff_div - 16'd1;
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    // State registers with asynchronous reset; reset also flushes the FIFO pointers.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RST) begin
            pending_q <= 1'b0;
            rdata_q   <= '0;
            clkdiv_q  <= CLKDIV_RESET;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            period_q  <= 16'd1;
            tx_q      <= 1'b1;
        end else begin
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
            clkdiv_q  <= clkdiv_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            tx_q      <= tx_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (push) mem[wr_ptr_q[AW-1:0]] <= wdata[31:24];
    end

endmodule
